// File: rtl/ins_loader.sv
// Boot-stream instruction loader.
// Accepts a byte stream: count (16-bit, little-endian), 4*count data bytes
// (MSB-first per word), then one XOR checksum byte. Each completed word is
// written to instruction memory with a one-cycle strobe. A good checksum
// releases the CPU. Any header or checksum fault latches a sticky error.
module ins_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        byteValid,
  input  logic [7:0]  byteIn,
  output logic        byteReady,
  output logic        romWrite,
  output logic [31:0] romAddr,
  output logic [31:0] romData,
  output logic        cpuRun,
  output logic [31:0] bootPC,
  output logic [15:0] loadedWords,
  output logic        loadError
);

  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE, CHK, DONE, ERROR
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] words_q;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic [7:0]  csum_q;
  logic [1:0]  idx_q;
  logic        wr_q;
  logic        run_q;
  logic        err_q;

  logic        accept_st;
  logic        xfer;
  logic [15:0] cnt_nxt;
  logic [15:0] words_nxt;

  // Byte acceptance is a pure state decode, forced low while reset is held
  // so the handshake drops immediately on reset assertion.
  assign accept_st = (state_q == HDR0) || (state_q == HDR1) ||
                     (state_q == DATA) || (state_q == CHK);
  assign byteReady = reset && accept_st;
  assign xfer      = byteValid && byteReady;

  // Full count as it will read once the high byte lands.
  assign cnt_nxt   = {byteIn, cnt_q[7:0]};
  assign words_nxt = words_q + 16'd1;

  assign romWrite    = wr_q;
  assign romAddr     = addr_q;
  assign romData     = data_q;
  assign cpuRun      = run_q;
  assign loadError   = err_q;
  assign loadedWords = words_q;
  assign bootPC      = BASE_ADDR;

  // Loader FSM: header parse, word assembly, write strobe, checksum verify.
  // addr_q tracks BASE_ADDR + 4*words_q incrementally so no multiplier is
  // needed and it wraps modulo 2^32 on its own.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= HDR0;
      cnt_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR;
      csum_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        HDR0: if (xfer) begin
          cnt_q[7:0] <= byteIn;
          state_q    <= HDR1;
        end
        HDR1: if (xfer) begin
          cnt_q[15:8] <= byteIn;
          if (cnt_nxt == 16'd0 || {16'd0, cnt_nxt} > MAX_WORDS) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (xfer) begin
          data_q <= {data_q[23:0], byteIn};
          csum_q <= csum_q ^ byteIn;
          idx_q  <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= WRITE;
            wr_q    <= 1'b1;
          end
        end
        WRITE: begin
          words_q <= words_nxt;
          addr_q  <= addr_q + 32'd4;
          state_q <= (words_nxt == cnt_q) ? CHK : DATA;
        end
        CHK: if (xfer) begin
          if (byteIn == csum_q) begin
            state_q <= DONE;
            run_q   <= 1'b1;
          end else begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        ERROR:   state_q <= ERROR;
        default: begin
          state_q <= ERROR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: the driver builds streams from a simple
// list-of-words model and queues the expected memory writes; a monitor pops
// and compares on every write strobe.
module tb_ins_loader;

  localparam int MAXW = 256;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteReady, romWrite, cpuRun, loadError;
  logic [31:0] romAddr, romData, bootPC;
  logic [15:0] loadedWords;

  always #5 CLK = ~CLK;

  ins_loader dut (
    .CLK(CLK), .reset(reset), .byteValid(byteValid), .byteIn(byteIn),
    .byteReady(byteReady), .romWrite(romWrite), .romAddr(romAddr),
    .romData(romData), .cpuRun(cpuRun), .bootPC(bootPC),
    .loadedWords(loadedWords), .loadError(loadError)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         expq[$];
  logic [31:0] wbuf[$];
  int          vecs = 0;
  int          errs = 0;
  logic        prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued write.
  always @(negedge CLK) begin
    wr_t e;
    if (reset && romWrite) begin
      chk("write_single_cycle", {31'd0, prev_wr}, 32'd0);
      chk("ready_low_in_write", {31'd0, byteReady}, 32'd0);
      if (expq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", romAddr, romData);
      end else begin
        e = expq.pop_front();
        chk("romAddr", romAddr, e.a);
        chk("romData", romData, e.d);
      end
    end
    prev_wr = reset && romWrite;
  end

  task automatic check_reset_vals();
    chk("rst_byteReady", {31'd0, byteReady}, 32'd0);
    chk("rst_romWrite", {31'd0, romWrite}, 32'd0);
    chk("rst_romAddr", romAddr, 32'h0);
    chk("rst_romData", romData, 32'h0);
    chk("rst_cpuRun", {31'd0, cpuRun}, 32'd0);
    chk("rst_loadedWords", {16'd0, loadedWords}, 32'd0);
    chk("rst_loadError", {31'd0, loadError}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    byteValid = 1'b0;
    reset = 1'b0;
    #1 check_reset_vals();
    chk("writes_pending_at_reset", expq.size(), 32'd0);
    expq.delete();
    @(negedge CLK);
    reset = 1'b1;
    #1 chk("ready_after_reset", {31'd0, byteReady}, 32'd1);
  endtask

  // Offer one byte (after a random idle gap) and wait for it to be taken.
  task automatic send(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      byteValid = 1'b0;
      @(negedge CLK);
    end
    byteValid = 1'b1;
    byteIn    = b;
    while (!byteReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!byteReady) begin
      vecs++; errs++;
      $display("FAIL byte_accept_timeout: byte %h not accepted within %0d cycles", b, n);
      byteValid = 1'b0;
      return;
    end
    @(negedge CLK);
    byteValid = 1'b0;
    byteIn    = $urandom();
  endtask

  // Bytes presented to a terminal state must never be taken.
  task automatic check_locked();
    byteValid = 1'b1;
    byteIn    = $urandom();
    repeat (3) begin
      @(negedge CLK);
      chk("terminal_ready_low", {31'd0, byteReady}, 32'd0);
    end
    byteValid = 1'b0;
  endtask

  // Send a stream for count cnt using words in wbuf; corrupt the checksum
  // if bad is set, then check the final status against the model.
  task automatic load(input logic [15:0] cnt, input bit bad);
    bit          ok_hdr = (cnt != 16'd0) && (int'(cnt) <= MAXW);
    logic [7:0]  x = 8'h00;
    logic [7:0]  cs;
    logic [31:0] w;
    send(cnt[7:0]);
    send(cnt[15:8]);
    if (!ok_hdr) begin
      repeat (2) @(negedge CLK);
      chk("hdr_err_loadError", {31'd0, loadError}, 32'd1);
      chk("hdr_err_cpuRun", {31'd0, cpuRun}, 32'd0);
      chk("hdr_err_words", {16'd0, loadedWords}, 32'd0);
      check_locked();
      chk("hdr_err_still_err", {31'd0, loadError}, 32'd1);
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      w = wbuf[i];
      expq.push_back('{32'(i) * 32'd4, w});
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    end
    cs = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    send(cs);
    repeat (3) @(negedge CLK);
    chk("end_cpuRun", {31'd0, cpuRun}, {31'd0, !bad});
    chk("end_loadError", {31'd0, loadError}, {31'd0, bad});
    chk("end_loadedWords", {16'd0, loadedWords}, {16'd0, cnt});
    chk("end_writes_outstanding", expq.size(), 32'd0);
    chk("bootPC", bootPC, 32'h0);
    check_locked();
    chk("end_cpuRun_held", {31'd0, cpuRun}, {31'd0, !bad});
  endtask

  task automatic fill_random(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back($urandom());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vecs %0d", vecs);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    #3;
    do_reset();

    // Single word with correct checksum 22.
    wbuf = '{32'hDEADBEEF};
    load(16'd1, 1'b0);

    // Three words, checksum 00.
    do_reset();
    wbuf = '{32'h11111111, 32'h22222222, 32'h33333333};
    load(16'd3, 1'b0);

    // Zero count and over-limit count.
    do_reset();
    load(16'h0000, 1'b0);
    do_reset();
    load(16'h0101, 1'b0);

    // Bad checksum on a single word.
    do_reset();
    wbuf = '{32'hDEADBEEF};
    load(16'd1, 1'b1);

    // Randomized streams.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      c = 16'($urandom_range(1, 8));
      fill_random(int'(c));
      load(c, ($urandom_range(0, 3) == 0));
    end

    // Maximum count accepted.
    do_reset();
    fill_random(MAXW);
    load(16'h0100, 1'b0);

    // Reset in the middle of a word: nothing written, outputs drop at once.
    do_reset();
    send(8'h01); send(8'h00); send(8'hAB); send(8'hCD);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    #1 chk("ready_after_midload_reset", {31'd0, byteReady}, 32'd1);
    wbuf = '{32'hCAFEF00D, 32'h01234567};
    load(16'd2, 1'b0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
